anspwm_stage_p: RTL and testbench



---
 rtl/anspwm_stage_p.sv | 173 +++++++++++++++++
 tb/tb_anspwm_stage_p.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anspwm_stage_p.sv
// anspwm_stage_p - one noise-shaping stage of the ANS PWM chain.
//
// Each valid target sample is split into a coarse level (Q) and a fine
// residual. The residual is re-scaled to full scale as the target for the
// next stage (nxttgt). An ORDER-th backward difference of the residual
// sequence is produced in sign-magnitude form (C, Csgn) for the final
// signed adder, optionally delayed by DELAY alignment registers.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear of pipeline, history and outputs
//   in_valid   A carries a new sample this cycle
//   A          unsigned target
//   Q          quantised level (A with low QSHIFT bits zeroed)
//   nxttgt     residual << (WIDTH-QSHIFT)
//   nxt_valid  Q/nxttgt updated this cycle
//   C          magnitude of the ORDER-th difference
//   Csgn       1 = difference negative (zero is always positive)
//   out_valid  C/Csgn updated this cycle
module anspwm_stage_p #(
  parameter int WIDTH  = 16,
  parameter int QSHIFT = 8,
  parameter int ORDER  = 3,
  parameter int DELAY  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] nxttgt,
  output logic             nxt_valid,
  output logic [WIDTH-1:0] C,
  output logic             Csgn,
  output logic             out_valid
);

  // One bit of headroom per difference order plus a sign bit keeps the
  // differences exact for every legal parameter set.
  localparam int DW = QSHIFT + ORDER + 1;
  localparam logic [WIDTH-1:0] LOW_MASK = {{(WIDTH-QSHIFT){1'b0}}, {QSHIFT{1'b1}}};

  // ---------------------------------------------------------------- stage 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q         <= '0;
      nxttgt    <= '0;
      nxt_valid <= 1'b0;
    end else if (clr) begin
      Q         <= '0;
      nxttgt    <= '0;
      nxt_valid <= 1'b0;
    end else begin
      nxt_valid <= in_valid;
      if (in_valid) begin
        Q      <= A & ~LOW_MASK;
        nxttgt <= A << (WIDTH - QSHIFT);
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  // The residual is recovered from the top of nxttgt rather than kept in a
  // separate register.
  logic [QSHIFT-1:0]     r_cur;
  logic signed [DW-1:0]  r_ext;
  logic signed [DW-1:0]  r_prev, d1_prev, d2_prev;
  logic signed [DW-1:0]  d1, d2, d3, d_sel;
  logic [DW-1:0]         d_mag;
  logic [WIDTH-1:0]      c_next;

  logic [WIDTH-1:0]      c_s2;
  logic                  sgn_s2;
  logic                  v_s2;

  assign r_cur = nxttgt[WIDTH-1 -: QSHIFT];
  assign r_ext = $signed({{(DW-QSHIFT){1'b0}}, r_cur});
  assign d1    = r_ext - r_prev;
  assign d2    = d1 - d1_prev;
  assign d3    = d2 - d2_prev;

  generate
    if (ORDER == 1) begin : g_ord1
      assign d_sel = d1;
    end else if (ORDER == 2) begin : g_ord2
      assign d_sel = d2;
    end else begin : g_ord3
      assign d_sel = d3;
    end
  endgenerate

  assign d_mag  = d_sel[DW-1] ? $unsigned(-d_sel) : $unsigned(d_sel);
  assign c_next = WIDTH'(d_mag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= '0;
      d1_prev <= '0;
      d2_prev <= '0;
      c_s2    <= '0;
      sgn_s2  <= 1'b0;
      v_s2    <= 1'b0;
    end else if (clr) begin
      r_prev  <= '0;
      d1_prev <= '0;
      d2_prev <= '0;
      c_s2    <= '0;
      sgn_s2  <= 1'b0;
      v_s2    <= 1'b0;
    end else begin
      v_s2 <= nxt_valid;
      // History advances only on real samples; gaps are not zero samples.
      if (nxt_valid) begin
        r_prev  <= r_ext;
        d1_prev <= d1;
        d2_prev <= d2;
        c_s2    <= c_next;
        sgn_s2  <= d_sel[DW-1];
      end
    end
  end

  // ------------------------------------------------------------- delay line
  // Data taps load only behind a valid, so C/Csgn hold through stalls at
  // every tap while the valid bit simply shifts.
  generate
    if (DELAY == 0) begin : g_nodly
      assign C         = c_s2;
      assign Csgn      = sgn_s2;
      assign out_valid = v_s2;
    end else begin : g_dly
      logic [WIDTH-1:0] tap_c [DELAY];
      logic             tap_s [DELAY];
      logic             tap_v [DELAY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < DELAY; k++) begin
            tap_c[k] <= '0;
            tap_s[k] <= 1'b0;
            tap_v[k] <= 1'b0;
          end
        end else if (clr) begin
          for (int k = 0; k < DELAY; k++) begin
            tap_c[k] <= '0;
            tap_s[k] <= 1'b0;
            tap_v[k] <= 1'b0;
          end
        end else begin
          tap_v[0] <= v_s2;
          if (v_s2) begin
            tap_c[0] <= c_s2;
            tap_s[0] <= sgn_s2;
          end
          for (int k = 1; k < DELAY; k++) begin
            tap_v[k] <= tap_v[k-1];
            if (tap_v[k-1]) begin
              tap_c[k] <= tap_c[k-1];
              tap_s[k] <= tap_s[k-1];
            end
          end
        end
      end

      assign C         = tap_c[DELAY-1];
      assign Csgn      = tap_s[DELAY-1];
      assign out_valid = tap_v[DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_anspwm_stage_p.sv
// Bench for anspwm_stage_p: three instances (defaults, ORDER=1, DELAY=3)
// share one stimulus stream and are compared against a reference model
// that evaluates the difference with the binomial form over the sample
// history since the last clear.
module tb_anspwm_stage_p;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] A = '0;

  logic [15:0] q0, n0, c0, q1, n1, c1, q2, n2, c2;
  logic        nv0, s0, ov0, nv1, s1, ov1, nv2, s2, ov2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  anspwm_stage_p u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .A(A),
    .Q(q0), .nxttgt(n0), .nxt_valid(nv0), .C(c0), .Csgn(s0), .out_valid(ov0));

  anspwm_stage_p #(.ORDER(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .A(A),
    .Q(q1), .nxttgt(n1), .nxt_valid(nv1), .C(c1), .Csgn(s1), .out_valid(ov1));

  anspwm_stage_p #(.DELAY(3)) u2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .A(A),
    .Q(q2), .nxttgt(n2), .nxt_valid(nv2), .C(c2), .Csgn(s2), .out_valid(ov2));

  // ------------------------------------------------------- reference model
  typedef struct {
    int          inst;
    int          due;
    logic [15:0] c;
    logic        s;
  } ent_t;

  int          ord [3] = '{3, 1, 3};
  int          dly [3] = '{0, 0, 3};
  int          hist[$];
  ent_t        pq[$];
  int          cyc = 0;
  logic [15:0] eq = '0, en = '0;
  logic        env = 1'b0;
  logic [15:0] ec [3] = '{16'h0, 16'h0, 16'h0};
  logic        es [3] = '{1'b0, 1'b0, 1'b0};
  logic        eov[3] = '{1'b0, 1'b0, 1'b0};

  logic [50:0] obs [3];
  logic [50:0] expv[3];

  assign obs[0]  = {q0, n0, nv0, c0, s0, ov0};
  assign obs[1]  = {q1, n1, nv1, c1, s1, ov1};
  assign obs[2]  = {q2, n2, nv2, c2, s2, ov2};
  assign expv[0] = {eq, en, env, ec[0], es[0], eov[0]};
  assign expv[1] = {eq, en, env, ec[1], es[1], eov[1]};
  assign expv[2] = {eq, en, env, ec[2], es[2], eov[2]};

  function automatic int binom(int n, int k);
    if (k == 0 || k == n) return 1;
    return n;  // only n<=3 is used: C(2,1)=2, C(3,1)=C(3,2)=3
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || clr) begin
        hist.delete();
        pq.delete();
        eq = '0; en = '0; env = 1'b0;
        for (int i = 0; i < 3; i++) begin
          ec[i] = '0; es[i] = 1'b0; eov[i] = 1'b0;
        end
      end else begin
        cyc++;
        env = 1'b0;
        for (int i = 0; i < 3; i++) eov[i] = 1'b0;
        for (int j = pq.size() - 1; j >= 0; j--) begin
          if (pq[j].due == cyc) begin
            eov[pq[j].inst] = 1'b1;
            ec[pq[j].inst]  = pq[j].c;
            es[pq[j].inst]  = pq[j].s;
            pq.delete(j);
          end
        end
        if (in_valid) begin
          int n;
          eq  = {A[15:8], 8'h00};
          en  = {A[7:0], 8'h00};
          env = 1'b1;
          hist.push_back(int'(A[7:0]));
          n = hist.size() - 1;
          for (int i = 0; i < 3; i++) begin
            int   d;
            ent_t e;
            d = 0;
            for (int k = 0; k <= ord[i]; k++)
              if (n - k >= 0)
                d += ((k % 2) ? -1 : 1) * binom(ord[i], k) * hist[n-k];
            e.inst = i;
            e.due  = cyc + 1 + dly[i];
            e.c    = 16'((d < 0) ? -d : d);
            e.s    = (d < 0);
            pq.push_back(e);
          end
        end
      end
    end
  end

  // --------------------------------------------------------------- helpers
  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // ----------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      A = 16'($urandom); in_valid = $urandom_range(0, 1) == 1;
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs[i] !== 51'h0) begin
          bad++;
          $display("FAIL reset_hold inst%0d got=%h exp=0", i, obs[i]);
        end
      end
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs[i] !== 51'h0) begin
          bad++;
          $display("FAIL reset_release inst%0d got=%h exp=0", i, obs[i]);
        end
      end
    end
  endtask

  task automatic test_single();
    do_clr();
    A = 16'h1234; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if ({q0, n0, nv0} !== {16'h1200, 16'h3400, 1'b1}) begin
      bad++;
      $display("FAIL single_stage1 got=%h/%h/%b exp=1200/3400/1", q0, n0, nv0);
    end
    @(negedge clk);
    total++;
    if ({c0, s0, ov0, nv0} !== {16'h0034, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL single_stage2 got=%h/%b/%b/%b exp=0034/0/1/0", c0, s0, ov0, nv0);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs[i] !== expv[i]) begin
        bad++;
        $display("FAIL single_model inst%0d got=%h exp=%h", i, obs[i], expv[i]);
      end
    end
  endtask

  task automatic test_const_stream();
    logic [16:0] e3 [5];
    logic [16:0] e1 [5];
    int k3 = 0;
    int k1 = 0;
    e3 = '{{16'h0034, 1'b0}, {16'h0068, 1'b1}, {16'h0034, 1'b0}, 17'h0, 17'h0};
    e1 = '{{16'h0034, 1'b0}, 17'h0, 17'h0, 17'h0, 17'h0};
    do_clr();
    A = 16'h1234; in_valid = 1'b1;
    for (int t = 1; t < 9; t++) begin
      @(negedge clk);
      if (ov0) begin
        total++;
        if (k3 >= 5 || {c0, s0} !== e3[k3]) begin
          bad++;
          $display("FAIL stream_ord3 idx%0d got=%h/%b", k3, c0, s0);
        end
        k3++;
      end
      if (ov1) begin
        total++;
        if (k1 >= 5 || {c1, s1} !== e1[k1]) begin
          bad++;
          $display("FAIL stream_ord1 idx%0d got=%h/%b", k1, c1, s1);
        end
        k1++;
      end
      in_valid = (t < 5);
    end
    total++;
    if (k3 != 5 || k1 != 5) begin
      bad++;
      $display("FAIL stream_count got=%0d/%0d exp=5/5", k3, k1);
    end
  endtask

  task automatic test_stall();
    logic [17:0] et [10];
    int pulses = 0;
    et = '{18'h0, 18'h0, {16'h0010, 2'b01}, {16'h0010, 2'b00}, {16'h0010, 2'b00},
           {16'h0010, 2'b00}, {16'h0020, 2'b01}, {16'h0020, 2'b00},
           {16'h0020, 2'b00}, {16'h0020, 2'b00}};
    do_clr();
    A = 16'h0010; in_valid = 1'b1;
    for (int t = 1; t < 10; t++) begin
      @(negedge clk);
      total++;
      if ({c1, s1, ov1} !== et[t]) begin
        bad++;
        $display("FAIL stall t%0d got=%h/%b/%b exp=%h", t, c1, s1, ov1, et[t]);
      end
      if (ov1) pulses++;
      in_valid = (t == 4);
      A = (t == 4) ? 16'h0030 : 16'h0010;
    end
    total++;
    if (pulses != 2) begin
      bad++;
      $display("FAIL stall_pulses got=%0d exp=2", pulses);
    end
  endtask

  task automatic test_delay();
    do_clr();
    A = 16'h00FF; in_valid = 1'b1;
    for (int t = 1; t < 9; t++) begin
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if ({nv2, ov2, c2, s2} !== {t == 1, t == 5, (t >= 5) ? 16'h00FF : 16'h0000, 1'b0}) begin
        bad++;
        $display("FAIL delay t%0d got nv=%b ov=%b c=%h s=%b", t, nv2, ov2, c2, s2);
      end
    end
  endtask

  task automatic test_clr_rst_mid(input bit use_rst);
    do_clr();
    for (int t = 0; t < 4; t++) begin
      A = 16'($urandom); in_valid = 1'b1;
      @(negedge clk);
    end
    A = 16'($urandom); in_valid = 1'b1;
    if (use_rst) begin
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs[i] !== 51'h0) begin
          bad++;
          $display("FAIL rst_async inst%0d got=%h exp=0", i, obs[i]);
        end
      end
    end else begin
      clr = 1'b1;
    end
    @(negedge clk);
    clr = 1'b0; rst_n = 1'b1; in_valid = 1'b0;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs[i] !== 51'h0) begin
          bad++;
          $display("FAIL %s_flush t%0d inst%0d got=%h exp=0", use_rst ? "rst" : "clr", t, i, obs[i]);
        end
      end
      @(negedge clk);
    end
    A = 16'h1234; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if ({q0, n0, nv0} !== {16'h1200, 16'h3400, 1'b1}) begin
      bad++;
      $display("FAIL after_flush_s1 got=%h/%h/%b exp=1200/3400/1", q0, n0, nv0);
    end
    @(negedge clk);
    total++;
    if ({c0, s0, ov0} !== {16'h0034, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL after_flush_s2 got=%h/%b/%b exp=0034/0/1", c0, s0, ov0);
    end
  endtask

  task automatic test_random();
    do_clr();
    for (int t = 0; t < 1500; t++) begin
      in_valid = $urandom_range(0, 3) != 0;
      A        = 16'($urandom);
      clr      = $urandom_range(0, 59) == 0;
      rst_n    = !(t == 700);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs[i] !== expv[i]) begin
          bad++;
          $display("FAIL random t%0d inst%0d got=%h exp=%h", t, i, obs[i], expv[i]);
        end
      end
    end
    clr = 1'b0; rst_n = 1'b1; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_const_stream();
    test_stall();
    test_delay();
    test_clr_rst_mid(1'b0);
    test_clr_rst_mid(1'b1);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
